mult_axi_sequencer: RTL and testbench
=====================================

# mult_axi_sequencer

AXI-lite master that drives one operation through the memory-mapped multiplier slave: it writes operand A (0x00), then operand B (0x04), waits a settle interval, then reads the product low word (0x08) and, optionally, the overflow flag (0x0C). It sits between a simple valid/ready request port and the multiplier's s2_axi port, serialising one multiply at a time and reporting timeouts and error responses.

## Interface

- DATA_WIDTH, 32, operand/bus data width
- ADDR_WIDTH, 8, AXI address width
- RESP_WIDTH, 3, bresp/rresp width (matches slave)
- SETTLE_CYCLES, 2, idle cycles between B-write completion and first read (≥1)
- TIMEOUT, 64, max cycles waited in any bus phase before abort (≥4)

- m1_axi_aclk  in  1  clock
- m1_axi_aresetn  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1  request handshake
- req_a, req_b  in  DATA_WIDTH  operands, captured on req_valid&&req_ready
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_product  out  DATA_WIDTH  product low word
- rsp_overflow  out  1  overflow flag (rdata bit 0)
- rsp_error  out  1  timeout or nonzero bresp/rresp seen
- m1_axi_awaddr  out  ADDR_WIDTH; m1_axi_awvalid out 1; m1_axi_awready in 1
- m1_axi_wdata  out  DATA_WIDTH; m1_axi_wstrb out DATA_WIDTH/8+1 (all ones); m1_axi_wvalid out 1; m1_axi_wready in 1
- m1_axi_bresp  in  RESP_WIDTH; m1_axi_bvalid in 1; m1_axi_bready out 1
- m1_axi_araddr  out  ADDR_WIDTH; m1_axi_arvalid out 1; m1_axi_arready in 1
- m1_axi_rdata  in  DATA_WIDTH; m1_axi_rresp in RESP_WIDTH; m1_axi_rvalid in 1; m1_axi_rready out 1

## Operation

- All outputs registered. Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_product=0, rsp_overflow=0, rsp_error=0, all AXI valids/readies=0, awaddr=araddr=0, wdata=0, wstrb all ones.
- States: IDLE → WR_A → GAP_A → WR_B → GAP_B → SETTLE → RD_LO → [RD_OV] → RESP → IDLE.
- IDLE: req_ready=1; on req_valid capture operands, clear rsp_error, go WR_A.
- WR_x: awaddr=0x00 (A) / 0x04 (B), wdata=operand, awvalid=wvalid=bready=1 held together. Complete on first edge with bvalid=1; bresp≠0 sets rsp_error (sequence continues). awready/wready are not required for completion.
- GAP_x: awvalid=wvalid=0, bready=1; leave when bvalid=0 sampled (guarantees the stale bvalid from the previous write is never taken as the next completion).
- SETTLE: count SETTLE_CYCLES edges, no bus activity.
- RD_x: araddr=0x08 (LO) / 0x0C (OV), arvalid=rready=1. Phase counter starts at 0 on entry; capture on first edge with rvalid=1 and counter ≥1 (slave rvalid is sticky; first-cycle data is stale). rresp≠0 sets rsp_error. LO → rsp_product=rdata; OV → rsp_overflow=rdata[0].
- RESP: rsp_valid=1, outputs stable until rsp_ready; then IDLE.
- Timeout: any WR/GAP/RD phase counter reaching TIMEOUT → drop all AXI valids, rsp_error=1, rsp_product and rsp_overflow=0, go RESP.
- Reset asserted mid-operation: immediate return to reset values; in-flight operation discarded, no response.

## Timing

- req handshake → awvalid high: 1 cycle.
- Each write: ≥2 cycles (WR) + ≥1 cycle (GAP) against the multiplier slave.
- Reads: ≥2 cycles each; product read issued SETTLE_CYCLES after GAP_B exit.
- req_ready=0 from capture until rsp handshake; back-to-back request accepted the cycle after rsp_valid&&rsp_ready.
- rsp_valid held indefinitely under rsp_ready=0; no output change while held.

## Configuration

- MULT_SEQ_OVF_READ_EN defined: RD_OV state present, 0x0C read performed, rsp_overflow reflects rdata[0].
- Undefined: RD_LO → RESP directly, rsp_overflow tied 0, one fewer bus read per operation.

## Test plan

- A=6, B=7 → writes 0x00=6, 0x04=7; read 0x08; rsp_product=42, rsp_overflow=0, rsp_error=0.
- A=0xFFFF_FFFF, B=2 (macro defined) → rsp_product=0xFFFF_FFFE, rsp_overflow=1; macro undefined → rsp_overflow=0, no 0x0C read observed.
- Slave model never raises bvalid on A write → after TIMEOUT=64 cycles rsp_valid=1, rsp_error=1, rsp_product=0, all AXI valids low.
- Slave holds bvalid high for 3 extra cycles after A write → B write not issued until bvalid=0; product still correct.
- rsp_ready held low 10 cycles → rsp_valid and data stable, req_ready=0; new request accepted cycle after release.
- aresetn pulsed low during RD_LO → all outputs at reset values same cycle, no rsp_valid; next request A=3, B=5 yields 15.

Source files
------------

// File: rtl/mult_axi_sequencer.sv
// mult_axi_sequencer: AXI-lite master running one multiply (write A, write B, settle, read product[, read overflow]).
// Optional overflow read enabled by defining MULT_SEQ_OVF_READ_EN.
module mult_axi_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int RESP_WIDTH    = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_product,
    output logic                    rsp_overflow,
    output logic                    rsp_error,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8:0]   m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic [RESP_WIDTH-1:0]   m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic [RESP_WIDTH-1:0]   m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);
`ifdef MULT_SEQ_OVF_READ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int CMAX = TIMEOUT > SETTLE_CYCLES ? TIMEOUT : SETTLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {IDLE, WR_A, GAP_A, WR_B, GAP_B, SETTLE, RD_LO, RD_OV, RESP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, prod_q, prod_d, wdata_q, wdata_d;
    logic                   ovf_q, ovf_d, err_q, err_d;
    logic                   req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                   awv_q, awv_d, bready_q, bready_d, arv_q, arv_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic                   unused_ready;

    // Handshake readies are not needed: bvalid/rvalid alone mark completion.
    assign unused_ready = &{1'b0, m1_axi_awready, m1_axi_wready, m1_axi_arready};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                a_d     = req_a;
                b_d     = req_b;
                err_d   = 1'b0;
                state_d = WR_A;
            end
            WR_A, WR_B: if (m1_axi_bvalid) begin
                err_d   = err_q | (|m1_axi_bresp);
                state_d = state_q == WR_A ? GAP_A : GAP_B;
            end
            GAP_A, GAP_B: if (!m1_axi_bvalid) state_d = state_q == GAP_A ? WR_B : SETTLE;
            SETTLE: if (cnt_q == ST_LAST) state_d = RD_LO;
            RD_LO: if (m1_axi_rvalid && cnt_q != '0) begin
                err_d   = err_q | (|m1_axi_rresp);
                prod_d  = m1_axi_rdata;
                state_d = OVF_EN ? RD_OV : RESP;
            end
            RD_OV: if (m1_axi_rvalid && cnt_q != '0) begin
                err_d   = err_q | (|m1_axi_rresp);
                ovf_d   = m1_axi_rdata[0];
                state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q inside {WR_A, GAP_A, WR_B, GAP_B, RD_LO, RD_OV} && state_d == state_q && cnt_q == TO_LAST) begin
            state_d = RESP;
            err_d   = 1'b1;
            prod_d  = '0;
            ovf_d   = 1'b0;
        end
        if (state_d != state_q) cnt_d = '0;
        // Bus outputs are a function of the next state so they change with the state register.
        req_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
        awv_d       = state_d inside {WR_A, WR_B};
        bready_d    = state_d inside {WR_A, GAP_A, WR_B, GAP_B};
        arv_d       = state_d inside {RD_LO, RD_OV};
        awaddr_d    = state_d == WR_B ? ADDR_WIDTH'(4) : '0;
        wdata_d     = state_d == WR_A ? a_d : state_d == WR_B ? b_d : '0;
        araddr_d    = state_d == RD_LO ? ADDR_WIDTH'(8) : state_d == RD_OV ? ADDR_WIDTH'(12) : '0;
    end

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            awv_q       <= 1'b0;
            bready_q    <= 1'b0;
            arv_q       <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            awv_q       <= awv_d;
            bready_q    <= bready_d;
            arv_q       <= arv_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_product    = prod_q;
    assign rsp_overflow   = ovf_q & OVF_EN;
    assign rsp_error      = err_q;
    assign m1_axi_awaddr  = awaddr_q;
    assign m1_axi_awvalid = awv_q;
    assign m1_axi_wvalid  = awv_q;
    assign m1_axi_wdata   = wdata_q;
    assign m1_axi_wstrb   = '1;
    assign m1_axi_bready  = bready_q;
    assign m1_axi_araddr  = araddr_q;
    assign m1_axi_arvalid = arv_q;
    assign m1_axi_rready  = arv_q;
endmodule

// File: tb/tb_mult_axi_sequencer.sv
// tb_mult_axi_sequencer: randomized bench with a multiplier-slave model and arithmetic reference for mult_axi_sequencer.
module tb_mult_axi_sequencer;
    localparam int TO = 64;
`ifdef MULT_SEQ_OVF_READ_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
    logic [31:0] req_a = '0, req_b = '0, rsp_product;
    logic rsp_overflow, rsp_error;
    logic [7:0] awaddr, araddr;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [4:0] wstrb;
    logic [2:0] bresp;
    logic s_bvalid, s_busy, s_rvalid;
    logic [2:0] s_bresp;
    logic [31:0] s_a, s_b, s_rdata;
    int s_bcnt, s_hold;
    bit k_never = 0, k_berr = 0;
    int k_delay = 0, k_extra = 0;
    logic [39:0] wr_log[$];
    logic [7:0] rd_log[$];
    bit aw4_bv[$];
    logic awv_p, arv_p;
    logic [7:0] ara_p;
    int checks = 0, errors = 0;
    wire [63:0] s_full = {32'b0, s_a} * {32'b0, s_b};

    always #5 clk = ~clk;

    mult_axi_sequencer dut (
        .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
        .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(1'b1),
        .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(1'b1),
        .m1_axi_bresp(bresp), .m1_axi_bvalid(s_bvalid), .m1_axi_bready(bready),
        .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(1'b1),
        .m1_axi_rdata(s_rdata), .m1_axi_rresp(3'd0), .m1_axi_rvalid(s_rvalid), .m1_axi_rready(rready)
    );

    assign bresp = s_bvalid ? s_bresp : 3'd0;

    // Multiplier slave: registered, sticky rvalid, configurable write-response latency/hold/error.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a <= '0; s_b <= '0; s_bvalid <= 0; s_busy <= 0; s_bresp <= '0; s_bcnt <= 0; s_hold <= 0;
            s_rvalid <= 0; s_rdata <= '0; awv_p <= 0; arv_p <= 0; ara_p <= '0;
        end else begin
            awv_p <= awvalid; arv_p <= arvalid; ara_p <= araddr;
            if (awvalid && awaddr == 8'h04 && !awv_p) aw4_bv.push_back(s_bvalid);
            if (arvalid && (!arv_p || araddr != ara_p)) rd_log.push_back(araddr);
            if (!s_busy) begin
                if (awvalid && wvalid) begin
                    if (awaddr == 8'h00) s_a <= wdata;
                    else if (awaddr == 8'h04) s_b <= wdata;
                    wr_log.push_back({awaddr, wdata});
                    s_busy <= 1; s_bcnt <= k_delay;
                    s_bresp <= (k_berr && awaddr == 8'h04) ? 3'd2 : 3'd0;
                end
            end else if (!s_bvalid) begin
                if (k_never) begin
                    if (!awvalid) s_busy <= 0;
                end else if (s_bcnt == 0) begin
                    s_bvalid <= 1; s_hold <= k_extra;
                end else s_bcnt <= s_bcnt - 1;
            end else if (bready) begin
                if (s_hold == 0) begin s_bvalid <= 0; s_busy <= 0; end
                else s_hold <= s_hold - 1;
            end
            if (arvalid) begin
                s_rvalid <= 1;
                s_rdata <= araddr == 8'h08 ? s_full[31:0] : araddr == 8'h0C ? {31'b0, |s_full[63:32]} : '0;
            end
        end
    end

    function automatic logic [32:0] model(input logic [31:0] a, b);
        logic [63:0] m;
        m = {32'b0, a} * {32'b0, b};
        return {OVF && m[63:32] != 0, m[31:0]};
    endfunction

    task automatic do_op(input logic [31:0] a, b, output logic [31:0] p, output logic o, e, output bit ok);
        int n;
        ok = 0;
        @(negedge clk); req_a = a; req_b = b; req_valid = 1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        ok = rsp_valid;
        p = rsp_product; o = rsp_overflow; e = rsp_error;
        rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_product, rsp_overflow, rsp_error, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata} !==
            {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'b0, 8'd0, 8'd0, 32'd0}) begin
            errors++; $display("FAIL reset_vals: rr=%b rv=%b p=%h o=%b e=%b awv=%b bready=%b arv=%b", req_ready, rsp_valid, rsp_product, rsp_overflow, rsp_error, awvalid, bready, arvalid);
        end
        checks++;
        if (wstrb !== 5'h1F) begin errors++; $display("FAIL reset_wstrb: got %h want 1f", wstrb); end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL post_reset: rr=%b rv=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_basic;
        logic [31:0] p; logic o, e; bit ok; int wb, rb;
        wb = wr_log.size(); rb = rd_log.size();
        do_op(32'd6, 32'd7, p, o, e, ok);
        checks++;
        if (!ok || {p, o, e} !== {32'd42, 1'b0, 1'b0}) begin errors++; $display("FAIL basic: ok=%0d p=%0d o=%b e=%b want 42 0 0", ok, p, o, e); end
        checks++;
        if (!(wr_log.size() == wb + 2 && wr_log[wb] == {8'h00, 32'd6} && wr_log[wb+1] == {8'h04, 32'd7})) begin
            errors++; $display("FAIL basic_writes: count=%0d want 2 (0x00=6, 0x04=7)", wr_log.size() - wb);
        end
        checks++;
        if (!(rd_log.size() == rb + (OVF ? 2 : 1) && rd_log[rb] == 8'h08 && (!OVF || rd_log[rb+1] == 8'h0C))) begin
            errors++; $display("FAIL basic_reads: count=%0d want %0d", rd_log.size() - rb, OVF ? 2 : 1);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] p; logic o, e; bit ok; int rb; bit saw_c;
        rb = rd_log.size();
        do_op(32'hFFFF_FFFF, 32'd2, p, o, e, ok);
        checks++;
        if (!ok || {p, o, e} !== {32'hFFFF_FFFE, OVF, 1'b0}) begin errors++; $display("FAIL overflow: p=%h o=%b e=%b want fffffffe %b 0", p, o, e, OVF); end
        saw_c = 0;
        for (int i = rb; i < rd_log.size(); i++) if (rd_log[i] == 8'h0C) saw_c = 1;
        checks++;
        if (saw_c !== OVF) begin errors++; $display("FAIL ovf_read_presence: saw 0x0C=%0d want %0d", saw_c, OVF); end
    endtask

    task automatic test_random;
        logic [31:0] a, b, p; logic o, e; bit ok; logic [32:0] m;
        for (int i = 0; i < 10; i++) begin
            a = (i % 3 == 0) ? $urandom_range(0, 65535) : $urandom;
            b = (i % 2 == 0) ? $urandom_range(0, 65535) : $urandom;
            k_delay = $urandom_range(0, 3); k_extra = $urandom_range(0, 2);
            m = model(a, b);
            do_op(a, b, p, o, e, ok);
            checks++;
            if (!ok || {o, p} !== m || e !== 1'b0) begin
                errors++; $display("FAIL random[%0d]: a=%h b=%h got p=%h o=%b e=%b want p=%h o=%b e=0", i, a, b, p, o, e, m[31:0], m[32]);
            end
        end
        k_delay = 0; k_extra = 0;
    endtask

    task automatic test_timeout;
        int n, aw;
        k_never = 1;
        @(negedge clk); req_a = 32'd5; req_b = 32'd5; req_valid = 1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 0;
        n = 0; aw = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); if (awvalid) aw++; n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL timeout_rsp: rsp_valid=%b want 1", rsp_valid); end
        checks++;
        if (aw < TO || aw > TO + 2) begin errors++; $display("FAIL timeout_len: awvalid cycles=%0d want %0d..%0d", aw, TO, TO + 2); end
        checks++;
        if ({rsp_error, rsp_product, rsp_overflow} !== {1'b1, 32'd0, 1'b0}) begin errors++; $display("FAIL timeout_vals: e=%b p=%h o=%b want 1 0 0", rsp_error, rsp_product, rsp_overflow); end
        checks++;
        if ({awvalid, wvalid, arvalid, rready} !== 4'b0) begin errors++; $display("FAIL timeout_bus: awv=%b wv=%b arv=%b rr=%b want 0", awvalid, wvalid, arvalid, rready); end
        rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
        k_never = 0;
    endtask

    task automatic test_bvalid_hold;
        logic [31:0] p; logic o, e; bit ok; int ab; logic [32:0] m;
        k_extra = 3; ab = aw4_bv.size();
        m = model(32'd1234, 32'd5678);
        do_op(32'd1234, 32'd5678, p, o, e, ok);
        checks++;
        if (!ok || {o, p} !== m || e !== 1'b0) begin errors++; $display("FAIL hold_result: p=%0d e=%b want %0d 0", p, e, m[31:0]); end
        checks++;
        if (!(aw4_bv.size() == ab + 1 && aw4_bv[ab] == 1'b0)) begin errors++; $display("FAIL hold_gap: B writes=%0d bvalid at B issue=%0d want 1 write, bvalid 0", aw4_bv.size() - ab, aw4_bv.size() > ab ? aw4_bv[ab] : 1'b1); end
        k_extra = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] p0; logic o0, e0; int n; bit stable;
        @(negedge clk); req_a = 32'd11; req_b = 32'd13; req_valid = 1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        p0 = rsp_product; o0 = rsp_overflow; e0 = rsp_error;
        checks++;
        if ({rsp_valid, p0, o0, e0} !== {1'b1, 32'd143, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_result: rv=%b p=%0d o=%b e=%b want 1 143 0 0", rsp_valid, p0, o0, e0); end
        req_a = 32'd20; req_b = 32'd30; req_valid = 1;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({rsp_valid, req_ready, rsp_product, rsp_overflow, rsp_error} !== {1'b1, 1'b0, p0, o0, e0}) stable = 0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_stable: rv=%b rr=%b p=%0d want held 1 0 %0d", rsp_valid, req_ready, rsp_product, p0); end
        rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL b2b_ready: rr=%b rv=%b want 1 0", req_ready, rsp_valid); end
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, awaddr, wdata} !== {1'b1, 1'b1, 8'h00, 32'd20}) begin errors++; $display("FAIL b2b_aw: awv=%b addr=%h wdata=%0d want 1 00 20", awvalid, awaddr, wdata); end
        n = 0;
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        checks++;
        if ({rsp_valid, rsp_product, rsp_error} !== {1'b1, 32'd600, 1'b0}) begin errors++; $display("FAIL b2b_result: rv=%b p=%0d e=%b want 1 600 0", rsp_valid, rsp_product, rsp_error); end
        rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] p; logic o, e; bit ok, quiet; int n;
        @(negedge clk); req_a = 32'd100; req_b = 32'd200; req_valid = 1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!(arvalid && araddr == 8'h08) && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!(arvalid && araddr == 8'h08)) begin errors++; $display("FAIL mid_reach_rd: arvalid=%b araddr=%h want 1 08", arvalid, araddr); end
        rst_n = 0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_product, rsp_overflow, rsp_error, awvalid, wvalid, bready, arvalid, rready, awaddr, araddr, wdata} !==
            {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5'b0, 8'd0, 8'd0, 32'd0}) begin
            errors++; $display("FAIL mid_reset_vals: rr=%b rv=%b arv=%b rready=%b araddr=%h", req_ready, rsp_valid, arvalid, rready, araddr);
        end
        quiet = 1;
        repeat (3) begin @(negedge clk); if (rsp_valid) quiet = 0; end
        rst_n = 1;
        repeat (3) begin @(negedge clk); if (rsp_valid) quiet = 0; end
        checks++;
        if (!quiet) begin errors++; $display("FAIL mid_no_rsp: rsp_valid seen=1 want 0"); end
        do_op(32'd3, 32'd5, p, o, e, ok);
        checks++;
        if (!ok || {p, o, e} !== {32'd15, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_after: p=%0d o=%b e=%b want 15 0 0", p, o, e); end
    endtask

    task automatic test_error_resp;
        logic [31:0] p; logic o, e; bit ok;
        k_berr = 1;
        do_op(32'd9, 32'd9, p, o, e, ok);
        checks++;
        if (!ok || {p, e} !== {32'd81, 1'b1}) begin errors++; $display("FAIL bresp_err: p=%0d e=%b want 81 1", p, e); end
        k_berr = 0;
        do_op(32'd2, 32'd3, p, o, e, ok);
        checks++;
        if (!ok || {p, e} !== {32'd6, 1'b0}) begin errors++; $display("FAIL err_cleared: p=%0d e=%b want 6 0", p, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_timeout();
        test_bvalid_hold();
        test_back_to_back();
        test_reset_mid();
        test_error_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
